// File: rtl/board_pkg.sv
// board_pkg: shared board geometry, cell encoding and garbage-insert state encodings
package board_pkg;
   localparam int BOARD_W = 10;
   localparam int BOARD_H = 24;
   localparam int ADDR_W = 8;
   localparam int CELL_W = 6;
   localparam logic [CELL_W-1:0] CELL_EMPTY = 6'd0;
   typedef enum logic [3:0] {
      IDLE, CHK_ADDR, CHK_WAIT, CHK_SAMPLE,
      SH_ADDR, SH_WAIT, SH_READ, SH_WRITE, SH_END,
      FL_PREP, FL_WRITE, FL_END, DONE
   } state_t;
endpackage

// File: rtl/coord_to_addr.sv
// coord_to_addr: maps a board (x, y) coordinate to its linear RAM address
module coord_to_addr
   import board_pkg::*;
#(
   parameter int BOARD_W = board_pkg::BOARD_W
) (
   input  logic [3:0]        x,
   input  logic [4:0]        y,
   output logic [ADDR_W-1:0] addr
);
   assign addr = ADDR_W'(32'(y) * BOARD_W + 32'(x));
endmodule

// File: rtl/garbage_row_insert.sv
// garbage_row_insert: shifts the board up one row and fills the bottom row with garbage
module garbage_row_insert
   import board_pkg::*;
#(
   parameter int BOARD_W = board_pkg::BOARD_W,
   parameter int BOARD_H = board_pkg::BOARD_H
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic [3:0]        hole_x,
   input  logic [CELL_W-1:0] garbage_colour,
   input  logic [CELL_W-1:0] ram_Q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [CELL_W-1:0] ram_data,
   output logic              ram_wren,
   output logic              complete,
   output logic              overflow
);
   state_t state, nxt;
   logic [3:0] x, hole;
   logic [CELL_W-1:0] colour;
   logic [ADDR_W-1:0] a, xy_addr;
   logic fl, last_x, last_a;

   assign fl = state inside {FL_PREP, FL_WRITE, FL_END};
   assign last_x = x == 4'(BOARD_W - 1);
   assign last_a = a == ADDR_W'(BOARD_W * BOARD_H - 1);

   coord_to_addr #(.BOARD_W(BOARD_W)) u_coord (
      .x   (x),
      .y   (fl ? 5'(BOARD_H - 1) : 5'd0),
      .addr(xy_addr)
   );

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= nxt;
   end

   // next state: walk check, shift and fill phases; enable low aborts to idle
   always_comb begin
      nxt = state;
      case (state)
         IDLE:       nxt = enable ? CHK_ADDR : IDLE;
         CHK_ADDR:   nxt = CHK_WAIT;
         CHK_WAIT:   nxt = CHK_SAMPLE;
         CHK_SAMPLE: nxt = last_x ? SH_ADDR : CHK_ADDR;
         SH_ADDR:    nxt = SH_WAIT;
         SH_WAIT:    nxt = SH_READ;
         SH_READ:    nxt = SH_WRITE;
         SH_WRITE:   nxt = SH_END;
         SH_END:     nxt = last_a ? FL_PREP : SH_ADDR;
         FL_PREP:    nxt = FL_WRITE;
         FL_WRITE:   nxt = FL_END;
         FL_END:     nxt = last_x ? DONE : FL_PREP;
         DONE:       nxt = DONE;
         default:    nxt = IDLE;
      endcase
      if (!enable) nxt = IDLE;
   end

   // registered RAM port, handshake outputs and cell counters
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ram_addr <= '0;
         ram_data <= '0;
         ram_wren <= 1'b0;
         complete <= 1'b0;
         overflow <= 1'b0;
         x        <= '0;
         a        <= '0;
         hole     <= '0;
         colour   <= '0;
      end else if (!enable && state != IDLE) begin
         ram_wren <= 1'b0;
         complete <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ram_addr <= '0;
               ram_data <= '0;
               ram_wren <= 1'b0;
               complete <= 1'b0;
               overflow <= 1'b0;
               x        <= '0;
               a        <= ADDR_W'(BOARD_W);
               hole     <= 32'(hole_x) >= BOARD_W ? 4'(BOARD_W - 1) : hole_x;
               colour   <= garbage_colour;
            end
            CHK_ADDR: ram_addr <= xy_addr;
            CHK_SAMPLE: begin
               overflow <= overflow | (ram_Q != CELL_EMPTY);
               x        <= last_x ? '0 : x + 4'd1;
            end
            SH_ADDR: ram_addr <= a;
            SH_READ: begin
               ram_data <= ram_Q;
               ram_addr <= a - ADDR_W'(BOARD_W);
            end
            SH_WRITE: ram_wren <= 1'b1;
            SH_END: begin
               ram_wren <= 1'b0;
               a        <= a + 8'd1;
            end
            FL_PREP: begin
               ram_addr <= xy_addr;
               ram_data <= x == hole ? CELL_EMPTY : colour;
            end
            FL_WRITE: ram_wren <= 1'b1;
            FL_END: begin
               ram_wren <= 1'b0;
               x        <= last_x ? '0 : x + 4'd1;
               complete <= last_x;
            end
            DONE: complete <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_garbage_row_insert.sv
// tb_garbage_row_insert: directed checks of garbage row insertion against a RAM model
module tb_garbage_row_insert;
   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       enable = 1'b0;
   logic [3:0] hole_x = 4'd0;
   logic [5:0] garbage_colour = 6'd1;
   logic [5:0] ram_q;
   logic [7:0] ram_addr;
   logic [5:0] ram_data;
   logic       ram_wren, complete, overflow;

   logic [5:0] mem [240];
   logic [5:0] img [240];
   logic       clr = 1'b0, ld = 1'b0;
   logic [7:0] ld_a = '0;
   logic [5:0] ld_d = '0;

   int tests = 0, fails = 0;
   int pulses = 0, width_bad = 0, stab_bad = 0, addr_bad = 0;
   logic       wren_q = 1'b0;
   logic [7:0] h1 = '0, h2 = '0;
   logic [5:0] d1 = '0;

   always #5 clk = ~clk;

   garbage_row_insert dut (
      .clk           (clk),
      .resetn        (resetn),
      .enable        (enable),
      .hole_x        (hole_x),
      .garbage_colour(garbage_colour),
      .ram_Q         (ram_q),
      .ram_addr      (ram_addr),
      .ram_data      (ram_data),
      .ram_wren      (ram_wren),
      .complete      (complete),
      .overflow      (overflow)
   );

   // board RAM: read data appears one edge after the address is seen
   always @(posedge clk) begin
      ram_q <= mem[ram_addr];
      if (clr) for (int i = 0; i < 240; i++) mem[i] <= '0;
      else if (ld) mem[ld_a] <= ld_d;
      else if (ram_wren) mem[ram_addr] <= ram_data;
   end

   // write-pulse monitor: width, setup stability, shift destination
   always @(posedge clk) begin
      if (ram_wren) begin
         pulses <= pulses + 1;
         if (wren_q) width_bad <= width_bad + 1;
         if (ram_addr != h1 || ram_data != d1) stab_bad <= stab_bad + 1;
         if (ram_addr < 8'd230 && h2 != ram_addr + 8'd10) addr_bad <= addr_bad + 1;
      end
      wren_q <= ram_wren;
      h1     <= ram_addr;
      h2     <= h1;
      d1     <= ram_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_board();
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 240; i++) img[i] = '0;
   endtask

   task automatic load(input int idx, input logic [5:0] v);
      ld = 1'b1;
      ld_a = 8'(idx);
      ld_d = v;
      tick();
      ld = 1'b0;
      img[idx] = v;
   endtask

   task automatic run(output int n);
      enable = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (!complete && n < 1300);
   endtask

   task automatic check_board(input int hole, input int colour);
      for (int i = 0; i < 240; i++)
         chk($sformatf("cell%0d", i), 32'(mem[i]),
             i < 230 ? 32'(img[i + 10]) : ((i - 230) == hole ? 32'd0 : 32'(colour)));
   endtask

   initial begin
      int n, base;
      repeat (3) tick();
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_data", 32'(ram_data), 0);
      chk("rst_wren", 32'(ram_wren), 0);
      chk("rst_complete", 32'(complete), 0);
      chk("rst_overflow", 32'(overflow), 0);
      @(negedge clk) resetn = 1'b1;
      tick();

      clear_board();
      load(23 * 10 + 3, 6'd5);
      hole_x = 4'd7;
      garbage_colour = 6'd9;
      base = pulses;
      run(n);
      chk("t1_cycles", 32'(n), 1211);
      chk("t1_complete", 32'(complete), 1);
      chk("t1_overflow", 32'(overflow), 0);
      chk("t1_moved", 32'(mem[22 * 10 + 3]), 5);
      chk("t1_pulses", 32'(pulses - base), 240);
      chk("t1_width", 32'(width_bad), 0);
      chk("t1_stable", 32'(stab_bad), 0);
      chk("t1_shift_dst", 32'(addr_bad), 0);
      check_board(7, 9);
      enable = 1'b0;
      tick();
      chk("t1_idle_complete", 32'(complete), 0);

      clear_board();
      load(0, 6'd2);
      load(239, 6'd4);
      hole_x = 4'd3;
      garbage_colour = 6'd1;
      run(n);
      chk("t2_cycles", 32'(n), 1211);
      chk("t2_overflow", 32'(overflow), 1);
      chk("t2_lost", 32'(mem[0]), 0);
      chk("t2_moved", 32'(mem[229]), 4);
      check_board(3, 1);
      repeat (3) tick();
      chk("t2_hold_complete", 32'(complete), 1);
      chk("t2_hold_overflow", 32'(overflow), 1);
      enable = 1'b0;
      tick();
      chk("t2_drop_complete", 32'(complete), 0);
      chk("t2_drop_overflow", 32'(overflow), 0);

      clear_board();
      hole_x = 4'd12;
      garbage_colour = 6'd7;
      run(n);
      chk("t3_cycles", 32'(n), 1211);
      chk("t3_hole", 32'(mem[239]), 0);
      chk("t3_fill0", 32'(mem[230]), 7);
      chk("t3_fill8", 32'(mem[238]), 7);
      check_board(9, 7);
      enable = 1'b0;
      tick();

      clear_board();
      load(15, 6'd3);
      hole_x = 4'd0;
      garbage_colour = 6'd2;
      enable = 1'b1;
      repeat (500) tick();
      enable = 1'b0;
      tick();
      base = pulses;
      chk("t4_wren", 32'(ram_wren), 0);
      chk("t4_complete", 32'(complete), 0);
      chk("t4_overflow", 32'(overflow), 0);
      repeat (20) tick();
      chk("t4_no_writes", 32'(pulses - base), 0);
      run(n);
      chk("t4_restart_cycles", 32'(n), 1211);
      chk("t4_restart_complete", 32'(complete), 1);
      enable = 1'b0;
      tick();

      clear_board();
      load(0, 6'd3);
      load(12, 6'd6);
      enable = 1'b1;
      repeat (44) tick();
      chk("t5_pre_addr", 32'(ram_addr), 2);
      chk("t5_pre_data", 32'(ram_data), 6);
      chk("t5_pre_overflow", 32'(overflow), 1);
      #2 resetn = 1'b0;
      #1;
      chk("t5_addr", 32'(ram_addr), 0);
      chk("t5_data", 32'(ram_data), 0);
      chk("t5_wren", 32'(ram_wren), 0);
      chk("t5_complete", 32'(complete), 0);
      chk("t5_overflow", 32'(overflow), 0);
      enable = 1'b0;
      @(negedge clk) resetn = 1'b1;
      tick();
      chk("t5_after_wren", 32'(ram_wren), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/garbage_row_insert.md
# garbage_row_insert

Pushes the whole playfield up by one row and inserts a garbage row at the bottom, i.e. the upward counterpart of the row-clear shift-down path. Sits beside the row-clear engine on the board RAM port, arbitrated by the game FSM through the same level `enable` / `complete` handshake. Reports overflow when the discarded top row held any block, so the game FSM can declare game over.

## Interface
- `BOARD_W`, default 10: cells per row.
- `BOARD_H`, default 24: rows; row 0 is the top; cell address = y*BOARD_W + x.
- `clk` in 1: system clock, rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `enable` in 1: level request; hold high until `complete`; low returns to idle.
- `hole_x` in 4: column left empty in the garbage row; values ≥ BOARD_W are treated as BOARD_W-1.
- `garbage_colour` in 6: cell code for filled garbage cells; must be nonzero.
- `ram_Q` in 6: board RAM read data.
- `ram_addr` out 8: board RAM address, registered.
- `ram_data` out 6: board RAM write data, registered.
- `ram_wren` out 1: board RAM write enable, registered.
- `complete` out 1: operation finished; held while `enable` is high.
- `overflow` out 1: top row was non-empty; valid while `complete` is high.

## Operation
- Cell code 0 means empty. RAM read: data for address A is on `ram_Q` at the second rising edge after the edge that set `ram_addr=A`.
- States: IDLE, CHK_ADDR, CHK_WAIT, CHK_SAMPLE, SH_ADDR, SH_WAIT, SH_READ, SH_WRITE, SH_END, FL_PREP, FL_WRITE, FL_END, DONE.
- IDLE: outputs 0. Latch the clamped `hole_x` and `garbage_colour`. Go to CHK_ADDR when `enable`=1.
- CHK (x=0..BOARD_W-1, 3 cycles/cell):
  - CHK_ADDR sets `ram_addr`=x.
  - CHK_SAMPLE ORs (`ram_Q`≠0) into the overflow flag.
- SH (a=BOARD_W .. BOARD_W*BOARD_H-1, ascending, 5 cycles/cell):
  - SH_ADDR sets `ram_addr`=a.
  - SH_READ sets `ram_data`=`ram_Q` and `ram_addr`=a-BOARD_W.
  - SH_WRITE sets `ram_wren`=1.
  - SH_END sets `ram_wren`=0, then advances to the next cell.
  - Ascending order guarantees every source cell is read before it is overwritten.
- FL (x=0..BOARD_W-1, 3 cycles/cell):
  - FL_PREP sets `ram_addr`=(BOARD_H-1)*BOARD_W+x and `ram_data`=(x==hole)?0:colour.
  - FL_WRITE sets `ram_wren`=1.
  - FL_END sets `ram_wren`=0.
- DONE: `complete`=1, `overflow` holds its result. When `enable`=0, go to IDLE and clear both.
- `overflow` does not stop the shift; the top row is discarded regardless.
- `enable` low in any non-IDLE state: next edge goes to IDLE with `ram_wren`=0, `complete`=0, `overflow`=0. The board may be partially shifted; recovery is the caller's responsibility.
- `resetn` low at any time: immediately IDLE, all outputs and counters 0.

## Timing
- Reset value of every output: 0.
- Default board: CHK 30 cycles, SH 230×5=1150 cycles, FL 30 cycles.
- `complete` rises on the 1211th rising edge, counting the edge that first samples `enable`=1.
- `ram_wren` is never high for more than one consecutive cycle. `ram_addr` and `ram_data` are stable for the whole cycle in which `ram_wren`=1 and for the cycle before it.
- Address arithmetic is 8-bit unsigned. Maximum address is 239; there is no wrap.
- `enable` re-asserted in the same cycle DONE exits still requires one IDLE cycle before CHK_ADDR.

## Structure
- Shared `board_pkg`: BOARD_W, BOARD_H, CELL_EMPTY=6'd0, ADDR_W=8, CELL_W=6, state encodings.
- One sub-module: the existing `coord_to_addr`, used for CHK and FL addressing. SH uses a linear address counter.
- Single always block plus a state register; no other sub-modules.

## Test plan
- Board with a single cell at (3,23)=5, `hole_x`=7, colour 9, `enable` held high:
  - (3,22)=5; row 23 is 9 everywhere except x=7, which is 0.
  - `overflow`=0; `complete` at edge 1211.
- (0,0)=2 and (9,23)=4:
  - `overflow`=1; (0,0) is lost; (9,22)=4; row 23 is garbage.
  - `complete` and `overflow` held until `enable` drops, then both 0 on the next edge.
- `hole_x`=12: hole at x=9; cells x=0..8 of row 23 equal the colour.
- `enable` dropped at cycle 500:
  - IDLE next edge, `ram_wren`=0, no further writes.
  - Restart completes normally in 1211 cycles.
- `resetn` pulsed low during SH_WRITE: `ram_wren`, `complete`, `overflow`, `ram_addr` and `ram_data` go to 0 asynchronously, before the next clock edge.
- Write-pulse monitor over a full run:
  - exactly 240 `ram_wren` pulses (230 shift + 10 fill), each one cycle wide.
  - shift writes land at source address minus 10.
